// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared control bit indices, default control width and skid buffer states
package ex_mem_pkg;
  localparam int CTRL_W_DEF = 5;
  localparam int CTRL_CREATEDUMP = 0;
  localparam int CTRL_WRITE_MEM = 1;
  localparam int CTRL_READ_MEM = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_REG_W_EN = 4;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;
endpackage

// File: rtl/ex_mem_pipe_if.sv
// ex_mem_pipe_if: EX->MEM handshake bundle; forwarding signals exist only with EX_MEM_PIPE_FWD_EN
interface ex_mem_pipe_if
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W = 3,
  parameter int CTRL_W = CTRL_W_DEF
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [REG_W-1:0] in_w_reg;
  logic [DATA_W-1:0] in_data_2;
  logic [DATA_W-1:0] in_alu_out;
  logic out_valid;
  logic out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [REG_W-1:0] out_w_reg;
  logic [DATA_W-1:0] out_data_2;
  logic [DATA_W-1:0] out_alu_out;
`ifdef EX_MEM_PIPE_FWD_EN
  logic fwd_valid;
  logic [REG_W-1:0] fwd_reg;
  logic [DATA_W-1:0] fwd_data;
`endif
  modport master(
`ifdef EX_MEM_PIPE_FWD_EN
    input fwd_valid, fwd_reg, fwd_data,
`endif
    output flush, in_valid, in_ctrl, in_w_reg, in_data_2, in_alu_out, out_ready,
    input in_ready, out_valid, out_ctrl, out_w_reg, out_data_2, out_alu_out
  );
  modport slave(
`ifdef EX_MEM_PIPE_FWD_EN
    output fwd_valid, fwd_reg, fwd_data,
`endif
    input flush, in_valid, in_ctrl, in_w_reg, in_data_2, in_alu_out, out_ready,
    output in_ready, out_valid, out_ctrl, out_w_reg, out_data_2, out_alu_out
  );
endinterface

// File: rtl/pipe_entry.sv
// pipe_entry: one pipeline entry register with load enable and synchronous active-low clear
module pipe_entry #(
  parameter int DATA_W = 16,
  parameter int REG_W = 3,
  parameter int CTRL_W = 5
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic [CTRL_W-1:0] ctrl,
  input logic [REG_W-1:0] w_reg,
  input logic [DATA_W-1:0] data_2,
  input logic [DATA_W-1:0] alu_out,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [REG_W-1:0] w_reg_q,
  output logic [DATA_W-1:0] data_2_q,
  output logic [DATA_W-1:0] alu_out_q
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q <= '0;
      w_reg_q <= '0;
      data_2_q <= '0;
      alu_out_q <= '0;
    end else if (load) begin
      ctrl_q <= ctrl;
      w_reg_q <= w_reg;
      data_2_q <= data_2;
      alu_out_q <= alu_out;
    end
  end
endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM stage as a two-entry skid buffer with flush and bubble-gated controls
// Optional forwarding outputs are built when EX_MEM_PIPE_FWD_EN is defined.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_W = 3,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input logic clk,
  input logic rst,
  ex_mem_pipe_if.slave bus
);
  skid_state_t state, state_n;
  logic in_ready, in_fire, out_valid, out_fire, h_load, s_load;
  logic [CTRL_W-1:0] h_ctrl, s_ctrl;
  logic [REG_W-1:0] h_w_reg, s_w_reg;
  logic [DATA_W-1:0] h_data_2, s_data_2, h_alu_out, s_alu_out;
  assign out_valid = state != EMPTY;
  assign in_fire = bus.in_valid & in_ready;
  assign out_fire = out_valid & bus.out_ready;
  always_comb begin
    state_n = bus.flush ? EMPTY :
              state == EMPTY ? (in_fire ? ONE : EMPTY) :
              state == ONE ? (in_fire && !out_fire ? TWO : !in_fire && out_fire ? EMPTY : ONE) :
              (out_fire ? ONE : TWO);
    h_load = !bus.flush && (state == EMPTY ? in_fire : state == ONE ? in_fire && out_fire : out_fire);
    s_load = !bus.flush && state == ONE && in_fire && !out_fire;
  end
  // in_ready comes from the next state, so out_ready never reaches it combinationally
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state <= state_n;
      in_ready <= state_n != TWO;
    end
  end
  pipe_entry #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) u_head (
    .clk(clk),
    .rst(rst),
    .load(h_load),
    .ctrl(state == TWO ? s_ctrl : bus.in_ctrl),
    .w_reg(state == TWO ? s_w_reg : bus.in_w_reg),
    .data_2(state == TWO ? s_data_2 : bus.in_data_2),
    .alu_out(state == TWO ? s_alu_out : bus.in_alu_out),
    .ctrl_q(h_ctrl),
    .w_reg_q(h_w_reg),
    .data_2_q(h_data_2),
    .alu_out_q(h_alu_out)
  );
  pipe_entry #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) u_skid (
    .clk(clk),
    .rst(rst),
    .load(s_load),
    .ctrl(bus.in_ctrl),
    .w_reg(bus.in_w_reg),
    .data_2(bus.in_data_2),
    .alu_out(bus.in_alu_out),
    .ctrl_q(s_ctrl),
    .w_reg_q(s_w_reg),
    .data_2_q(s_data_2),
    .alu_out_q(s_alu_out)
  );
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_ctrl = h_ctrl & {CTRL_W{out_valid}};
  assign bus.out_w_reg = h_w_reg;
  assign bus.out_data_2 = h_data_2;
  assign bus.out_alu_out = h_alu_out;
`ifdef EX_MEM_PIPE_FWD_EN
  // loads resolve in MEM, so only pure ALU results are forwardable here
  assign bus.fwd_valid = out_valid & h_ctrl[CTRL_REG_W_EN] & ~h_ctrl[CTRL_MEM_TO_REG];
  assign bus.fwd_reg = bus.fwd_valid ? h_w_reg : '0;
  assign bus.fwd_data = bus.fwd_valid ? h_alu_out : '0;
`endif
endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: directed self-checking bench for ex_mem_pipe (define EX_MEM_PIPE_FWD_EN to cover forwarding)
module tb_ex_mem_pipe;
  import ex_mem_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  ex_mem_pipe_if bus();
  ex_mem_pipe dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [4:0] c, input logic [2:0] r, input logic [15:0] a);
    bus.in_valid = v;
    bus.in_ctrl = c;
    bus.in_w_reg = r;
    bus.in_data_2 = ~a;
    bus.in_alu_out = a;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 5'b11111, 3'd7, 16'haaaa);
    for (int i = 0; i < 2; i++) begin
      step();
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_chk++; if (bus.out_ctrl !== 5'd0) begin n_fail++; $display("FAIL reset_out_ctrl: got %b want 00000", bus.out_ctrl); end
      n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
      n_chk++; if ({bus.out_w_reg, bus.out_data_2, bus.out_alu_out} !== 35'd0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", {bus.out_w_reg, bus.out_data_2, bus.out_alu_out}); end
    end
    rst = 1'b1;
    drive(1'b0, 5'd0, 3'd0, 16'h0);
    step();
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_out_valid: got %b want 0", bus.out_valid); end
  endtask
  task automatic test_stream();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'b10000, 3'(i), 16'(i));
      step();
      n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.out_valid); end
      n_chk++; if (bus.out_alu_out !== 16'(i)) begin n_fail++; $display("FAIL stream_alu[%0d]: got %h want %h", i, bus.out_alu_out, 16'(i)); end
      n_chk++; if (bus.out_data_2 !== ~16'(i)) begin n_fail++; $display("FAIL stream_data2[%0d]: got %h want %h", i, bus.out_data_2, ~16'(i)); end
      n_chk++; if (bus.out_w_reg !== 3'(i)) begin n_fail++; $display("FAIL stream_wreg[%0d]: got %0d want %0d", i, bus.out_w_reg, 3'(i)); end
      n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
    end
    drive(1'b0, 5'd0, 3'd0, 16'h0);
    step();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b want 0", bus.out_valid); end
  endtask
  task automatic test_backpressure();
    bus.out_ready = 1'b1;
    drive(1'b1, 5'b00010, 3'd1, 16'h0010);
    step();
    n_chk++; if (bus.out_alu_out !== 16'h0010) begin n_fail++; $display("FAIL bp_first: got %h want 0010", bus.out_alu_out); end
    bus.out_ready = 1'b0;
    drive(1'b1, 5'b00010, 3'd2, 16'h0011);
    step();
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %b want 0", bus.in_ready); end
    n_chk++; if (bus.out_alu_out !== 16'h0010) begin n_fail++; $display("FAIL bp_full_head: got %h want 0010", bus.out_alu_out); end
    drive(1'b1, 5'b00010, 3'd3, 16'h0012);
    step();
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_in_ready: got %b want 0", bus.in_ready); end
    n_chk++; if (bus.out_alu_out !== 16'h0010) begin n_fail++; $display("FAIL bp_hold_head: got %h want 0010", bus.out_alu_out); end
    n_chk++; if (bus.out_ctrl !== 5'b00010) begin n_fail++; $display("FAIL bp_hold_ctrl: got %b want 00010", bus.out_ctrl); end
    bus.out_ready = 1'b1;
    step();
    n_chk++; if (bus.out_alu_out !== 16'h0011) begin n_fail++; $display("FAIL bp_rel_skid: got %h want 0011", bus.out_alu_out); end
    n_chk++; if (bus.out_w_reg !== 3'd2) begin n_fail++; $display("FAIL bp_rel_wreg: got %0d want 2", bus.out_w_reg); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rel_in_ready: got %b want 1", bus.in_ready); end
    step();
    n_chk++; if (bus.out_alu_out !== 16'h0012) begin n_fail++; $display("FAIL bp_last: got %h want 0012", bus.out_alu_out); end
    n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_last_valid: got %b want 1", bus.out_valid); end
    drive(1'b0, 5'd0, 3'd0, 16'h0);
    step();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
  endtask
  task automatic test_flush();
    bus.out_ready = 1'b1;
    drive(1'b1, 5'b00110, 3'd4, 16'h0030);
    step();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'b00110, 3'd5, 16'h0031);
    step();
    n_chk++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_in_ready: got %b want 0", bus.in_ready); end
    bus.flush = 1'b1;
    drive(1'b1, 5'b11111, 3'd6, 16'h0020);
    step();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    n_chk++; if (bus.out_ctrl !== 5'd0) begin n_fail++; $display("FAIL flush_ctrl: got %b want 00000", bus.out_ctrl); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    step();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_accept_drop: got %b want 0", bus.out_valid); end
    bus.flush = 1'b0;
    drive(1'b0, 5'd0, 3'd0, 16'h0);
    bus.out_ready = 1'b1;
    step();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after: got %b want 0", bus.out_valid); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after_in_ready: got %b want 1", bus.in_ready); end
  endtask
  task automatic test_bubble();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'b11111, 3'd5, 16'h0055);
    step();
    n_chk++; if (bus.out_ctrl !== 5'b11111) begin n_fail++; $display("FAIL bubble_head_ctrl: got %b want 11111", bus.out_ctrl); end
    drive(1'b0, 5'd0, 3'd0, 16'h0);
    bus.out_ready = 1'b1;
    step();
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b want 0", bus.out_valid); end
    n_chk++; if (bus.out_ctrl !== 5'd0) begin n_fail++; $display("FAIL bubble_ctrl: got %b want 00000", bus.out_ctrl); end
    n_chk++; if (bus.out_alu_out !== 16'h0055) begin n_fail++; $display("FAIL bubble_alu_hold: got %h want 0055", bus.out_alu_out); end
    n_chk++; if (bus.out_w_reg !== 3'd5) begin n_fail++; $display("FAIL bubble_wreg_hold: got %0d want 5", bus.out_w_reg); end
  endtask
`ifdef EX_MEM_PIPE_FWD_EN
  task automatic test_fwd();
    logic [4:0] c;
    c = '0;
    c[CTRL_REG_W_EN] = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b1, c, 3'd3, 16'h1234);
    step();
    n_chk++; if (bus.fwd_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_valid: got %b want 1", bus.fwd_valid); end
    n_chk++; if (bus.fwd_reg !== 3'd3) begin n_fail++; $display("FAIL fwd_reg: got %0d want 3", bus.fwd_reg); end
    n_chk++; if (bus.fwd_data !== 16'h1234) begin n_fail++; $display("FAIL fwd_data: got %h want 1234", bus.fwd_data); end
    c[CTRL_MEM_TO_REG] = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, c, 3'd3, 16'h1234);
    step();
    n_chk++; if (bus.fwd_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_load_valid: got %b want 0", bus.fwd_valid); end
    n_chk++; if (bus.fwd_data !== 16'h0) begin n_fail++; $display("FAIL fwd_load_data: got %h want 0000", bus.fwd_data); end
    drive(1'b0, 5'd0, 3'd0, 16'h0);
    step();
    n_chk++; if (bus.fwd_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_empty: got %b want 0", bus.fwd_valid); end
  endtask
`endif
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
`ifdef EX_MEM_PIPE_FWD_EN
    test_fwd();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_mem_pipe.md
# ex_mem_pipe

Parametrised EX→MEM pipeline stage replacing the fixed enable-only stage register. It carries the memory/write-back control bundle, destination register and two data words. A two-entry skid buffer gives a valid/ready handshake with registered `in_ready`, full throughput, flush, and bubble gating of side-effecting controls. It sits between the execute stage (upstream producer) and the memory stage (downstream consumer).

## Interface
Parameters:
- `DATA_W`, 16, width of `data_2` and `alu_out` words
- `REG_W`, 3, destination register index width
- `CTRL_W`, 5, control bundle width; bit order: [0] createdump, [1] write_mem, [2] read_mem, [3] mem_to_reg, [4] reg_w_en

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; synchronous, active-low
- `flush`  in  1  discard all held and incoming entries this cycle
- `in_valid`  in  1  upstream entry present
- `in_ready`  out  1  stage can accept (registered)
- `in_ctrl`  in  CTRL_W  control bundle
- `in_w_reg`  in  REG_W  destination register
- `in_data_2`  in  DATA_W  store data
- `in_alu_out`  in  DATA_W  ALU result / address
- `out_valid`  out  1  entry presented downstream
- `out_ready`  in  1  downstream accepts
- `out_ctrl`  out  CTRL_W  control bundle, gated by `out_valid`
- `out_w_reg`, `out_data_2`, `out_alu_out`  out  REG_W/DATA_W/DATA_W  head entry fields (ungated)
- `fwd_valid`, `fwd_reg`, `fwd_data`  out  1/REG_W/DATA_W  present only with `EX_MEM_PIPE_FWD_EN`

## Operation
- Storage: head entry H (drives outputs) and skid entry S. States: EMPTY, ONE (H valid), TWO (H and S valid).
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- EMPTY: in_fire → ONE, H←in.
- ONE: in_fire & out_fire → ONE, H←in; in_fire only → TWO, S←in; out_fire only → EMPTY.
- TWO: in_ready=0; out_fire → ONE, H←S; else hold.
- `in_ready` = (next state ≠ TWO), registered; `out_valid` = (state ≠ EMPTY).
- `out_ctrl` = H.ctrl & {CTRL_W{out_valid}} — bubbles never write memory, write registers or dump.
- `flush` (priority over all handshakes): next state EMPTY, any same-cycle in_fire discarded, `in_ready`←1. A same-cycle out_fire still counts as taken by downstream.
- Data fields of H/S update only on load; they hold otherwise (no needless toggling).
- Reset (rst=0 at clk edge): state EMPTY, all entry fields 0, `in_ready`=0 during reset cycle, 1 on first cycle after release; `out_valid`=0, all outputs 0.
- Reset asserted mid-transfer: all entries lost, no partial state retained.

## Timing
- Latency: in_fire at edge n → `out_valid` with that entry after edge n (visible cycle n+1).
- Throughput: one entry/cycle sustained when `out_ready`=1.
- `in_ready` drops the cycle after the stage enters TWO; at most one extra entry is absorbed after `out_ready` falls.
- Ordering strictly FIFO; no entry duplicated or dropped except by flush/reset.
- No combinational path from `out_ready` to `in_ready`.

## Configuration
- `EX_MEM_PIPE_FWD_EN` defined: forwarding ports present; `fwd_valid` = out_valid & H.ctrl[4] & ~H.ctrl[3]; `fwd_reg` = H.w_reg; `fwd_data` = H.alu_out; all 0 when `fwd_valid`=0.
- Undefined: forwarding ports and logic absent; remaining behaviour identical.

## Structure
- Shared package `ex_mem_pkg`: control bit index constants (CTRL_CREATEDUMP … CTRL_REG_W_EN), CTRL_W default, skid state enum (EMPTY/ONE/TWO).
- One sub-module: `pipe_entry` — parametrised entry register (ctrl, w_reg, data_2, alu_out) with load enable and synchronous active-low clear; instantiated for H and S.

## Test plan
- Reset: rst=0 two cycles with in_valid=1 → out_valid=0, out_ctrl=0, all outputs 0; in_ready=1 one cycle after rst=1.
- Streaming: 8 entries alu_out=0x0001..0x0008, out_ready=1 → outputs 0x0001..0x0008 on consecutive cycles, 1-cycle latency.
- Backpressure: out_ready=0 after entry 0x0010 accepted, in_valid held with 0x0011,0x0012 → 0x0011 absorbed in S, in_ready=0; release → 0x0010, 0x0011, 0x0012 in order, none lost.
- Flush in TWO with in_valid=1 (0x0020) → next cycle out_valid=0, out_ctrl=0, 0x0020 never appears, in_ready=1.
- Bubble gating: H holds ctrl=5'b11111 then out_fire with no new input → out_valid=0, out_ctrl=0, out_alu_out retains old value.
- With `EX_MEM_PIPE_FWD_EN`: H ctrl reg_w_en=1, mem_to_reg=0, w_reg=3, alu_out=0x1234 → fwd_valid=1, fwd_reg=3, fwd_data=0x1234; mem_to_reg=1 → fwd_valid=0, fwd_data=0.
